// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with a two-deep output/skid buffer and valid/ready on both sides.
// Define IMM_GEN_ZICSR_EN to decode SYSTEM opcodes (CSR zimm as fmt Z, CSR address as fmt I).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_Z = 3'd6
  } fmt_e;

  logic [31:0]     imm32;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_NONE;
    dec_ill = (inst[1:0] != 2'b11);
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        if (inst[14]) begin
          dec_fmt = FMT_Z;
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{inst[31]}}, inst[31:20]};
        end
      end
`endif
      default: ;
    endcase
    if (dec_ill) begin
      dec_fmt = FMT_NONE;
      imm32   = '0;
    end
    // zimm is the only zero-extended immediate; everything else sign-extends from bit 31
    dec_imm = (dec_fmt == FMT_Z) ? XLEN'(inst[19:15]) : XLEN'($signed(imm32));
  end

`ifndef IMM_GEN_ZICSR_EN
  logic unused_funct3;
  assign unused_funct3 = ^inst[14:12];
`endif

  logic             o_valid_q, o_valid_d, s_valid_q, s_valid_d;
  logic [XLEN-1:0]  o_imm_q, o_imm_d, s_imm_q, s_imm_d;
  fmt_e             o_fmt_q, o_fmt_d, s_fmt_q, s_fmt_d;
  logic             o_ill_q, o_ill_d, s_ill_q, s_ill_d;
  logic [TAG_W-1:0] o_tag_q, o_tag_d, s_tag_q, s_tag_d;
  logic             in_fire, out_fire;

  assign in_ready = rst_n & ~s_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = o_valid_q & out_ready;

  always_comb begin
    o_valid_d = o_valid_q;
    o_imm_d   = o_imm_q;
    o_fmt_d   = o_fmt_q;
    o_ill_d   = o_ill_q;
    o_tag_d   = o_tag_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_fmt_d   = s_fmt_q;
    s_ill_d   = s_ill_q;
    s_tag_d   = s_tag_q;
    if (s_valid_q) begin
      // in_ready is low here, so only the skid-to-output move can happen
      if (out_fire) begin
        o_valid_d = 1'b1;
        o_imm_d   = s_imm_q;
        o_fmt_d   = s_fmt_q;
        o_ill_d   = s_ill_q;
        o_tag_d   = s_tag_q;
        s_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!o_valid_q || out_ready) begin
        o_valid_d = 1'b1;
        o_imm_d   = dec_imm;
        o_fmt_d   = dec_fmt;
        o_ill_d   = dec_ill;
        o_tag_d   = in_tag;
      end else begin
        s_valid_d = 1'b1;
        s_imm_d   = dec_imm;
        s_fmt_d   = dec_fmt;
        s_ill_d   = dec_ill;
        s_tag_d   = in_tag;
      end
    end else if (out_fire) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_imm_q   <= '0;
      o_fmt_q   <= FMT_NONE;
      o_ill_q   <= 1'b0;
      o_tag_q   <= '0;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_fmt_q   <= FMT_NONE;
      s_ill_q   <= 1'b0;
      s_tag_q   <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_imm_q   <= o_imm_d;
      o_fmt_q   <= o_fmt_d;
      o_ill_q   <= o_ill_d;
      o_tag_q   <= o_tag_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_fmt_q   <= s_fmt_d;
      s_ill_q   <= s_ill_d;
      s_tag_q   <= s_tag_d;
    end
  end

  assign out_valid = o_valid_q;
  assign imm_out   = o_imm_q;
  assign fmt       = o_fmt_q;
  assign illegal   = o_ill_q;
  assign out_tag   = o_tag_q;

endmodule
